barrier_scroller: RTL and testbench

BARRIER_SCROLLER -- requirements
Module: barrier_scroller

---
 rtl/game_pkg.sv | 21 ++
 rtl/lfsr_gen.sv | 32 +++
 rtl/barrier_scroller.sv | 147 ++++++++++++++
 tb/tb_barrier_scroller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared types and constants for the barrier scroller game logic.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } game_state_t;

  localparam int unsigned c_lfsr_width  = 8;
  // Galois right-shift mask for x^8+x^6+x^5+x^4+1 (maximal length)
  localparam logic [c_lfsr_width-1:0] c_lfsr_taps = 8'hB8;
  localparam int unsigned c_score_width = 16;

endpackage : game_pkg
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_gen
// Purpose  : Free-running Galois LFSR, advances every clock, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_gen #(
  parameter int unsigned        WIDTH = 8,
  parameter logic [WIDTH-1:0]   SEED  = WIDTH'(1),
  parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= SEED;
    end else if (r_value[0]) begin
      r_value <= (r_value >> 1) ^ TAPS;
    end else begin
      r_value <= r_value >> 1;
    end
  end

  assign value = r_value;

endmodule : lfsr_gen
`default_nettype wire

// File: rtl/barrier_scroller.sv
`default_nettype none
// ============================================================================
// Module   : barrier_scroller
// Purpose  : Multi-lane scrolling barrier track with LFSR injection, collision
//            detection and optional score counter (BARRIER_SCROLLER_SCORE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module barrier_scroller
  import game_pkg::*;
#(
  parameter int unsigned              TRACK_LEN = 40,
  parameter int unsigned              LANES     = 2,
  parameter int unsigned              HIT_POS   = 37,
  parameter int unsigned              MIN_GAP   = 2,
  parameter logic [c_lfsr_width-1:0]  LFSR_SEED = 8'h91
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  input  logic                         restart,
  input  logic [LANES-1:0]             player_mask,
  output logic [LANES*TRACK_LEN-1:0]   track,
  output logic                         collide,
  output logic                         running,
  output logic [c_score_width-1:0]     score
);

  localparam int unsigned c_gap_w = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [c_gap_w-1:0] c_gap_load = c_gap_w'(MIN_GAP);

  game_state_t                 r_state;
  logic [LANES*TRACK_LEN-1:0]  r_track;
  logic [LANES*TRACK_LEN-1:0]  w_track_next;
  logic [c_gap_w-1:0]          r_gap;
  logic [c_gap_w-1:0]          w_gap_next;
  logic                        r_collide;
  logic                        r_running;
  logic [c_lfsr_width-1:0]     w_lfsr;
  logic [31:0]                 w_lane_sel;
  logic                        w_do_inject;
  logic                        w_hit;
  logic [LANES-1:0]            w_hit_vec;
  logic [LANES-1:0]            w_inject;

  lfsr_gen #(
    .WIDTH (c_lfsr_width),
    .SEED  (LFSR_SEED),
    .TAPS  (c_lfsr_taps)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (w_lfsr)
  );

  // Injection only when the spacing counter has drained; upper LFSR bits pick the lane.
  assign w_lane_sel  = 32'(w_lfsr[c_lfsr_width-1:1]) % LANES;
  assign w_do_inject = (r_gap == '0) && w_lfsr[0];
  assign w_gap_next  = w_do_inject      ? c_gap_load :
                       (r_gap != '0)    ? r_gap - c_gap_w'(1) : r_gap;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_inject[l]  = w_do_inject && (w_lane_sel == 32'(l));
    assign w_hit_vec[l] = r_track[l*TRACK_LEN + HIT_POS] & player_mask[l];
    assign w_track_next[l*TRACK_LEN +: TRACK_LEN] =
      {r_track[l*TRACK_LEN +: TRACK_LEN-1], w_inject[l]};
  end

  assign w_hit = (r_state == RUN) && (|w_hit_vec);

  // Restart outranks hit, which outranks a scroll tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_track   <= '0;
      r_gap     <= '0;
      r_collide <= 1'b0;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (restart) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_track   <= '0;
            r_gap     <= '0;
          end
        end
        RUN: begin
          if (restart) begin
            r_track <= '0;
            r_gap   <= '0;
          end else if (w_hit) begin
            r_state   <= HIT;
            r_collide <= 1'b1;
            r_running <= 1'b0;
          end else if (tick) begin
            r_track <= w_track_next;
            r_gap   <= w_gap_next;
          end
        end
        HIT: begin
          if (restart) begin
            r_state   <= RUN;
            r_collide <= 1'b0;
            r_running <= 1'b1;
            r_track   <= '0;
            r_gap     <= '0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_track   <= '0;
          r_gap     <= '0;
          r_collide <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign track   = r_track;
  assign collide = r_collide;
  assign running = r_running;

`ifdef BARRIER_SCROLLER_SCORE_EN
  logic [c_score_width-1:0] r_score;
  logic                     w_score_inc;

  assign w_score_inc = (r_state == RUN) && tick && !restart && !w_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_score <= '0;
    end else if (restart) begin
      r_score <= '0;
    end else if (w_score_inc && (r_score != '1)) begin
      r_score <= r_score + c_score_width'(1);
    end
  end

  assign score = r_score;
`else
  assign score = '0;
`endif

endmodule : barrier_scroller
`default_nettype wire

// File: tb/tb_barrier_scroller.sv
`default_nettype none
// ============================================================================
// Module   : tb_barrier_scroller
// Purpose  : Self-checking bench for barrier_scroller (table vectors + sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_barrier_scroller;

  localparam int TL      = 40;
  localparam int LANES   = 2;
  localparam int HIT_POS = 37;
  localparam int MIN_GAP = 2;
`ifdef BARRIER_SCROLLER_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              tick = 1'b0;
  logic              restart = 1'b0;
  logic [LANES-1:0]  player_mask = '0;
  logic [LANES*TL-1:0] track;
  logic              collide;
  logic              running;
  logic [15:0]       score;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sc   = 0;

  barrier_scroller #(
    .TRACK_LEN (TL),
    .LANES     (LANES),
    .HIT_POS   (HIT_POS),
    .MIN_GAP   (MIN_GAP),
    .LFSR_SEED (8'h91)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .restart     (restart),
    .player_mask (player_mask),
    .track       (track),
    .collide     (collide),
    .running     (running),
    .score       (score)
  );

  always #5 clk = ~clk;

  // Reference track model: LFSR written bitwise from the polynomial.
  logic [7:0]        m_lfsr;
  int                m_state;
  int                m_gap;
  logic [LANES*TL-1:0] m_track;
  logic              m_hit;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    logic [7:0] n;
    n[7] = v[0];
    n[6] = v[7];
    n[5] = v[6] ^ v[0];
    n[4] = v[5] ^ v[0];
    n[3] = v[4] ^ v[0];
    n[2] = v[3];
    n[1] = v[2];
    n[0] = v[1];
    return n;
  endfunction

  function automatic logic [LANES*TL-1:0] model_shift(input logic [LANES*TL-1:0] t,
                                                      input int lane, input bit inj);
    logic [LANES*TL-1:0] n;
    n = '0;
    for (int l = 0; l < LANES; l++) begin
      n[l*TL +: TL] = {t[l*TL +: TL-1], (inj && (lane == l))};
    end
    return n;
  endfunction

  assign m_hit = (m_state == 1) &&
                 ((m_track[HIT_POS] & player_mask[0]) || (m_track[TL+HIT_POS] & player_mask[1]));

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr  <= 8'h91;
      m_state <= 0;
      m_track <= '0;
      m_gap   <= 0;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      if (restart) begin
        m_state <= 1;
        m_track <= '0;
        m_gap   <= 0;
      end else if (m_state == 1 && m_hit) begin
        m_state <= 2;
      end else if (m_state == 1 && tick) begin
        m_track <= model_shift(m_track, int'(m_lfsr[7:1]) % LANES, (m_gap == 0) && m_lfsr[0]);
        m_gap   <= ((m_gap == 0) && m_lfsr[0]) ? MIN_GAP : ((m_gap > 0) ? m_gap - 1 : 0);
      end
    end
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] es(input int v);
    if (!SCORE_EN) return 16'h0;
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic bit gaps_ok(input logic [LANES*TL-1:0] t);
    int last;
    last = -100;
    for (int c = 0; c < TL; c++) begin
      if (t[c] | t[TL+c]) begin
        if (c - last < MIN_GAP + 1) return 1'b0;
        last = c;
      end
    end
    return 1'b1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scroll with no player until a ground barrier sits at the hit column.
  task automatic hunt(output bit found);
    found = 1'b0;
    player_mask = '0;
    tick = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cyc();
      exp_sc++;
      if (track[HIT_POS]) begin
        found = 1'b1;
        break;
      end
    end
    tick = 1'b0;
  endtask

  typedef struct {
    logic        restart;
    logic        tick;
    logic [1:0]  mask;
    logic        exp_running;
    logic        exp_collide;
    int          exp_score;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;

    vecs[0] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 2};
    vecs[4] = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 2};
    vecs[5] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 3};
    vecs[6] = '{1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 0};
    vecs[7] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1};
    vecs[8] = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 2};
    vecs[9] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2};

    // Reset state
    repeat (2) cyc();
    chk("rst_track",   80'(track),   80'h0);
    chk("rst_collide", 80'(collide), 80'h0);
    chk("rst_running", 80'(running), 80'h0);
    chk("rst_score",   80'(score),   80'h0);
    chk("rst_lfsr",    80'(dut.w_lfsr), 80'h91);
    rst = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < 10; i++) begin
      restart = vecs[i].restart;
      tick = vecs[i].tick;
      player_mask = vecs[i].mask;
      cyc();
      chk($sformatf("vec%0d_running", i), 80'(running), 80'(vecs[i].exp_running));
      chk($sformatf("vec%0d_collide", i), 80'(collide), 80'(vecs[i].exp_collide));
      chk($sformatf("vec%0d_score", i),   80'(score),   80'(es(vecs[i].exp_score)));
      chk($sformatf("vec%0d_track", i),   80'(track),   80'(m_track));
    end
    chk("idle_track_model_sane", 80'(vecs[0].exp_running), 80'h0);

    // Restart then ten ticks
    restart = 1'b1; tick = 1'b0; player_mask = '0;
    cyc();
    restart = 1'b0; tick = 1'b1;
    exp_sc = 0;
    repeat (10) begin
      cyc();
      exp_sc++;
    end
    tick = 1'b0;
    chk("ten_running", 80'(running), 80'h1);
    chk("ten_score",   80'(score),   80'(es(10)));
    chk("ten_gaps",    80'(gaps_ok(track)), 80'h1);
    chk("ten_track",   80'(track),   80'(m_track));

    // Air player, ground barrier at hit column: passes through
    hunt(found);
    chk("hunt1_found", 80'(found), 80'h1);
    player_mask = 2'b10; tick = 1'b1;
    cyc();
    exp_sc++;
    player_mask = '0; tick = 1'b0;
    chk("air_collide", 80'(collide), 80'h0);
    chk("air_pass38",  80'(track[HIT_POS+1]), 80'h1);
    chk("air_score",   80'(score), 80'(es(exp_sc)));

    // Ground player, ground barrier at hit column: collision, then frozen
    hunt(found);
    chk("hunt2_found", 80'(found), 80'h1);
    player_mask = 2'b01; tick = 1'b0;
    cyc();
    chk("hit_collide", 80'(collide), 80'h1);
    chk("hit_running", 80'(running), 80'h0);
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    chk("hit_frozen_track", 80'(track), 80'(m_track));
    chk("hit_frozen_col37", 80'(track[HIT_POS]), 80'h1);
    chk("hit_frozen_score", 80'(score), 80'(es(exp_sc)));
    chk("hit_still_collide", 80'(collide), 80'h1);

    // Restart out of HIT
    player_mask = '0; restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("rehit_running", 80'(running), 80'h1);
    chk("rehit_collide", 80'(collide), 80'h0);
    chk("rehit_track",   80'(track),   80'h0);
    chk("rehit_score",   80'(score),   80'h0);

    // Reset in the middle of a run: immediate clear
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    chk("pre_rst_score", 80'(score), 80'(es(3)));
    rst = 1'b0;
    #2;
    chk("mid_rst_track",   80'(track),   80'h0);
    chk("mid_rst_collide", 80'(collide), 80'h0);
    chk("mid_rst_running", 80'(running), 80'h0);
    chk("mid_rst_score",   80'(score),   80'h0);
    chk("mid_rst_lfsr",    80'(dut.w_lfsr), 80'h91);
    cyc();
    rst = 1'b1;
    tick = 1'b1;
    repeat (2) cyc();
    tick = 1'b0;
    chk("post_rst_idle_running", 80'(running), 80'h0);
    chk("post_rst_idle_track",   80'(track),   80'h0);

    // Score saturation
    restart = 1'b1;
    cyc();
    restart = 1'b0; tick = 1'b1;
    for (int i = 0; i < 65534; i++) cyc();
    chk("sat_fffe", 80'(score), 80'(SCORE_EN ? 16'hFFFE : 16'h0));
    repeat (3) cyc();
    tick = 1'b0;
    chk("sat_ffff", 80'(score), 80'(SCORE_EN ? 16'hFFFF : 16'h0));
    chk("sat_track", 80'(track), 80'(m_track));
    chk("sat_running", 80'(running), 80'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_barrier_scroller
`default_nettype wire
